// File: rtl/seq_tx_pkg.sv
// -----------------------------------------------------------------------------
// seq_tx_pkg
// Shared constants for the sequence-detector family: the transmitter FSM state
// encoding and the default widths used by the serializer and the detectors.
// No ports (package).
// -----------------------------------------------------------------------------
package seq_tx_pkg;

   // Transmitter FSM state encoding (kept as plain constants so older
   // detector blocks can compare against them directly).
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   // Default parameter values shared with the detector blocks.
   localparam int SEQ_PAT_W = 4;
   localparam int SEQ_CNT_W = 8;
   localparam int SEQ_GAP_W = 4;

endpackage

// File: rtl/seq_tx_down_counter.sv
// -----------------------------------------------------------------------------
// seq_tx_down_counter
// Loadable down-counter with a zero flag. Load has priority over decrement.
// Callers never decrement at zero, so no saturation logic is needed.
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset (count cleared to 0)
//   i_load      load i_load_val on the next edge
//   i_load_val  value to load
//   i_dec       decrement by one on the next edge (ignored when i_load=1)
//   o_zero      high while the registered count is 0
// -----------------------------------------------------------------------------
module seq_tx_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_count <= '0;
      else if (i_load) r_count <= i_load_val;
      else if (i_dec)  r_count <= r_count - W'(1);
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/sequence_tx_serializer.sv
// -----------------------------------------------------------------------------
// sequence_tx_serializer
// Latches a PAT_W-bit pattern on an accepted start and shifts it out MSB-first,
// repeat_cnt+1 times, with `gap` idle cycles between repetitions. A one-cycle
// `done` pulse marks the last busy cycle; `abort` cancels without `done`.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          transfer request (sampled only in IDLE)
//   abort          synchronous cancel (honoured outside IDLE)
//   pattern        bits to send, MSB first
//   repeat_cnt     extra repetitions
//   gap            idle cycles between repetitions
//   dout           serial data bit
//   dout_valid     dout carries a pattern bit
//   busy           transfer in progress
//   done           one-cycle completion pulse
// All outputs are registers.
// -----------------------------------------------------------------------------
module sequence_tx_serializer
   import seq_tx_pkg::*;
#(
   parameter int PAT_W = SEQ_PAT_W,
   parameter int CNT_W = SEQ_CNT_W,
   parameter int GAP_W = SEQ_GAP_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam int               IDX_W   = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic             r_armed;       // start accepted last edge; SHIFT begins next edge
   logic [PAT_W-1:0] r_pat;
   logic [PAT_W-1:0] r_shift;       // MSB is the bit on dout; zero outside SHIFT
   logic [PAT_W-1:0] w_shift_next;
   logic [GAP_W-1:0] r_gap;
   logic             r_dout_valid;
   logic             r_busy;
   logic             r_done;

   logic w_accept;
   logic w_idx_reload;
   logic w_idx_dec;
   logic w_rep_dec;
   logic w_gap_load;
   logic w_gap_dec;
   logic w_idx_zero;
   logic w_rep_zero;
   logic w_gap_zero;

   seq_tx_down_counter #(.W(IDX_W)) u_idx_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_accept | w_idx_reload),
      .i_load_val (IDX_TOP),
      .i_dec      (w_idx_dec),
      .o_zero     (w_idx_zero)
   );

   seq_tx_down_counter #(.W(CNT_W)) u_rep_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_accept),
      .i_load_val (repeat_cnt),
      .i_dec      (w_rep_dec),
      .o_zero     (w_rep_zero)
   );

   // Loaded with gap-1 so the zero flag rises on the last gap cycle.
   seq_tx_down_counter #(.W(GAP_W)) u_gap_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_gap_load),
      .i_load_val (r_gap - GAP_W'(1)),
      .i_dec      (w_gap_dec),
      .o_zero     (w_gap_zero)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_idx_reload = 1'b0;
      w_idx_dec    = 1'b0;
      w_rep_dec    = 1'b0;
      w_gap_load   = 1'b0;
      w_gap_dec    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // The armed cycle holds off a second start until SHIFT is entered.
            if (r_armed)    w_state_next = ST_SHIFT;
            else if (start) w_accept     = 1'b1;
         end
         ST_SHIFT: begin
            if (abort)            w_state_next = ST_IDLE;
            else if (!w_idx_zero) w_idx_dec    = 1'b1;
            else if (w_rep_zero)  w_state_next = ST_DONE;
            else begin
               w_rep_dec = 1'b1;
               if (r_gap != '0) begin
                  w_state_next = ST_GAP;
                  w_gap_load   = 1'b1;
               end else begin
                  w_idx_reload = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (abort)            w_state_next = ST_IDLE;
            else if (!w_gap_zero) w_gap_dec    = 1'b1;
            else begin
               w_state_next = ST_SHIFT;
               w_idx_reload = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;   // ST_DONE: one cycle, abort or not
      endcase
   end

   // Entering SHIFT without a decrement means a new repetition starts.
   always_comb begin
      w_shift_next = '0;
      if (w_state_next == ST_SHIFT) begin
         if (w_idx_dec) w_shift_next = {r_shift[PAT_W-2:0], 1'b0};
         else           w_shift_next = r_pat;
      end
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_armed      <= 1'b0;
         r_pat        <= '0;
         r_gap        <= '0;
         r_shift      <= '0;
         r_dout_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_armed      <= w_accept;
         r_shift      <= w_shift_next;
         r_dout_valid <= (w_state_next == ST_SHIFT);
         r_busy       <= (w_state_next != ST_IDLE);
         r_done       <= (w_state_next == ST_DONE);
         if (w_accept) begin
            r_pat <= pattern;
            r_gap <= gap;
         end
      end
   end

   assign dout       = r_shift[PAT_W-1];
   assign dout_valid = r_dout_valid;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_sequence_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_sequence_tx_serializer
// Self-checking bench for sequence_tx_serializer. A reference model expands
// (pattern, repeats, gap) into the expected per-cycle output stream
// {dout, dout_valid, busy, done}; directed and random transfers are compared
// against it cycle by cycle.
// -----------------------------------------------------------------------------
module tb_sequence_tx_serializer;

   localparam int PAT_W = 4;
   localparam int CNT_W = 8;
   localparam int GAP_W = 4;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic             abort;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] repeat_cnt;
   logic [GAP_W-1:0] gap;
   logic             dout;
   logic             dout_valid;
   logic             busy;
   logic             done;

   int         n_pass  = 0;
   int         n_total = 0;
   logic [3:0] exp_q[$];    // expected {dout, dout_valid, busy, done} per cycle
   logic       obs_bits[$]; // valid bits seen during the last transfer

   sequence_tx_serializer #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W),
      .GAP_W (GAP_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .pattern    (pattern),
      .repeat_cnt (repeat_cnt),
      .gap        (gap),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_total++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // Expected stream: every repetition sends the pattern MSB first, gap idle
   // cycles sit between repetitions, then one done cycle, then idle.
   task automatic build_model(input logic [PAT_W-1:0] pat, input int reps, input int gp);
      exp_q.delete();
      for (int r = 0; r <= reps; r++) begin
         for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
         if (r < reps) begin
            for (int g = 0; g < gp; g++) exp_q.push_back(4'b0010);
         end
      end
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b0000);
   endtask

   // One transfer. pulse_a/pulse_b: cycles in which start is re-pulsed with
   // pattern 0; abort_at: cycle in which abort is raised (0 = never).
   task automatic run_xfer(input string tag, input logic [PAT_W-1:0] pat, input int reps,
                           input int gp, input int pulse_a, input int pulse_b,
                           input int abort_at, input logic abort_with_start);
      int busy_seen;
      busy_seen = 0;
      build_model(pat, reps, gp);
      if (abort_at > 0) begin
         while (exp_q.size() > abort_at) void'(exp_q.pop_back());
         repeat (4) exp_q.push_back(4'b0000);
      end
      obs_bits.delete();
      start      = 1'b1;
      abort      = abort_with_start;
      pattern    = pat;
      repeat_cnt = CNT_W'(reps);
      gap        = GAP_W'(gp);
      tick();
      start = 1'b0;
      abort = 1'b0;
      check({tag, "_latency"}, {dout, dout_valid, busy, done}, 4'b0000);
      for (int i = 0; i < exp_q.size(); i++) begin
         // Inputs wander while busy; the transfer must not notice.
         if (!start) begin
            pattern    = PAT_W'($urandom);
            repeat_cnt = CNT_W'($urandom);
            gap        = GAP_W'($urandom);
         end
         tick();
         check($sformatf("%s_c%0d", tag, i + 1), {dout, dout_valid, busy, done}, exp_q[i]);
         if (dout_valid) obs_bits.push_back(dout);
         if (busy) busy_seen++;
         start = (i + 1 == pulse_a) || (i + 1 == pulse_b);
         if (start) pattern = '0;
         abort = (i + 1 == abort_at);
      end
      start = 1'b0;
      abort = 1'b0;
      if (abort_at == 0)
         check({tag, "_busy_cycles"}, busy_seen, (reps + 1) * PAT_W + reps * gp + 1);
   endtask

   initial begin
      int         det;
      logic [7:0] stream;

      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      pattern    = '0;
      repeat_cnt = '0;
      gap        = '0;
      tick();
      tick();
      check("reset_outputs", {dout, dout_valid, busy, done}, 4'b0000);
      reset_n = 1'b1;
      tick();
      check("idle_after_reset", {dout, dout_valid, busy, done}, 4'b0000);

      // Single transmission, then back-to-back repeat with detector view.
      run_xfer("single_1101", 4'b1101, 0, 0, 0, 0, 0, 1'b0);
      run_xfer("b2b_1101", 4'b1101, 1, 0, 0, 0, 0, 1'b0);
      check("b2b_valid_bits", obs_bits.size(), 8);
      stream = '0;
      for (int i = 0; i < obs_bits.size(); i++) stream = {stream[6:0], obs_bits[i]};
      check("b2b_stream", stream, 8'b11011101);
      det = 0;
      for (int i = 3; i < obs_bits.size(); i++)
         if ({obs_bits[i-3], obs_bits[i-2], obs_bits[i-1], obs_bits[i]} == 4'b1101) det++;
      check("b2b_detector_hits", det, 2);

      // Repeat with a 2-cycle gap, then start re-pulsed in cycles 2 and 5;
      // the next transfer is started in cycle 6.
      run_xfer("gap2_1101", 4'b1101, 1, 2, 0, 0, 0, 1'b0);
      run_xfer("repulse_1101", 4'b1101, 0, 0, 2, 5, 0, 1'b0);
      run_xfer("after_repulse", 4'b0110, 0, 0, 0, 0, 0, 1'b0);

      // Abort while bit 3 is shown, abort inside a gap, start+abort in IDLE.
      run_xfer("abort_bit3", 4'b1101, 0, 0, 0, 0, 1, 1'b0);
      run_xfer("abort_gap", 4'b1011, 2, 3, 0, 0, 6, 1'b0);
      run_xfer("start_with_abort", 4'b1101, 0, 0, 0, 0, 0, 1'b1);

      // Widest gap field value.
      run_xfer("max_gap", 4'b1001, 2, 15, 0, 0, 0, 1'b0);

      // Asynchronous reset mid-SHIFT.
      start      = 1'b1;
      pattern    = 4'b1111;
      repeat_cnt = 8'd3;
      gap        = 4'd1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("rst_mid_pre", {dout, dout_valid, busy, done}, 4'b1110);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_async", {dout, dout_valid, busy, done}, 4'b0000);
      tick();
      check("rst_mid_held", {dout, dout_valid, busy, done}, 4'b0000);
      reset_n = 1'b1;
      tick();
      check("rst_mid_released", {dout, dout_valid, busy, done}, 4'b0000);
      run_xfer("after_reset", 4'b1010, 1, 1, 0, 0, 0, 1'b0);

      // Random transfers.
      for (int t = 0; t < 10; t++)
         run_xfer($sformatf("rnd%0d", t), PAT_W'($urandom), $urandom_range(0, 4),
                  $urandom_range(0, 3), 0, 0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sequence_tx_serializer.md
# sequence_tx_serializer

Serial pattern transmitter for the sequence-detector FSM family. Latches a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clock, repeated a programmable number of times with an optional idle gap between repetitions. It sits upstream of the detector blocks and drives their `din` input, both as functional stimulus and as a built-in self-test source. A one-cycle `done` pulse reports completion; a synchronous `abort` cancels a transfer.

## Interface
- `PAT_W`, default 4: pattern length in bits (≥2).
- `CNT_W`, default 8: width of the repeat-count field.
- `GAP_W`, default 4: width of the inter-repetition gap field.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  transfer request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; honoured in any non-IDLE state.
- `pattern`  in  PAT_W  bits to send, MSB first; latched on accepted start.
- `repeat_cnt`  in  CNT_W  extra repetitions (transmissions = repeat_cnt+1); latched on accepted start.
- `gap`  in  GAP_W  idle cycles between repetitions; latched on accepted start.
- `dout`  out  1  serial data bit.
- `dout_valid`  out  1  high when `dout` carries a pattern bit.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT, GAP, DONE. Moore outputs, registered; no output depends combinationally on inputs.
- IDLE: `start`=1 latches pattern/repeat_cnt/gap, loads bit index = PAT_W-1 and rep counter = repeat_cnt, moves to SHIFT. `start` ignored in all other states.
- SHIFT: `dout` = latched pattern[bit index], `dout_valid`=1. Index decrements each cycle. At index 0: if rep counter = 0, go to DONE; else decrement the rep counter and go to GAP if gap≠0, else reload index = PAT_W-1 and stay in SHIFT (back-to-back, so 1101 repeated reads 11011101…).
- GAP: `dout`=0, `dout_valid`=0 for exactly `gap` cycles, then reload index and go to SHIFT.
- DONE: `done`=1, `dout`=0, `dout_valid`=0 for one cycle, then IDLE. `start` in DONE is ignored; a new start is accepted from the following IDLE cycle.
- `abort`=1 in SHIFT/GAP/DONE → IDLE next edge, no `done` pulse. `abort` has priority over all transitions. `abort` in IDLE has no effect; `start` and `abort` both high in IDLE → start accepted.
- Counters saturate-free: the index is $clog2(PAT_W) bits, the rep counter CNT_W bits and the gap counter GAP_W bits; a wrap below 0 is unreachable by construction.
- Changes to `pattern`/`repeat_cnt`/`gap` inputs while busy have no effect.

## Timing
- Reset (`reset_n`=0, immediate): state IDLE; `dout`=0, `dout_valid`=0, `busy`=0, `done`=0; all latched fields cleared. Reset mid-transfer aborts with no `done`.
- Start accepted at edge k: first bit visible after edge k+1 (1-cycle latency); `busy` rises after edge k+1.
- Total busy cycles = (R+1)·PAT_W + R·gap + 1, where R = repeat_cnt.
- `done` is high for exactly one cycle, which is the last `busy` cycle; `busy` falls on the next edge.

## Structure
- Package `seq_tx_pkg`: state encoding constants (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and default parameter values shared with the detector blocks.
- Single sub-module `seq_tx_down_counter` (loadable down-counter with a zero flag), instantiated three times for the bit index, the repetitions and the gap.

## Test plan
- pattern=4'b1101, repeat_cnt=0, gap=0, start pulse → `dout` 1,1,0,1 with `dout_valid`=1 for cycles 1–4, `done`=1 in cycle 5, `busy` high for 5 cycles.
- pattern=4'b1101, repeat_cnt=1, gap=0 → 8 contiguous valid bits 11011101, `done` in cycle 9; the downstream overlapping 1101 detector flags twice.
- pattern=4'b1101, repeat_cnt=1, gap=2 → 1101, two cycles with `dout_valid`=0, then 1101; `done` in cycle 11.
- `start` re-pulsed in cycles 2 and 5 of the first scenario with pattern=4'b0000 → ignored; the output stream is unchanged and a new start is accepted in cycle 6.
- `abort` in the cycle where bit 3 is shown → IDLE next edge, `busy`=0, no `done` pulse; `start` with `abort` both high in IDLE → transfer begins.
- `reset_n` asserted asynchronously mid-SHIFT → all outputs 0 before the next edge; after release, a fresh start works normally.
